// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the two-core shared-memory arbiter: default widths
// and the access FSM state encoding.
package shared_mem_arbiter_pkg;

    localparam int NCORES_DEF = 2;
    localparam int LMEM_DEF   = 8;
    localparam int TAM_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDWAIT
    } state_t;

endpackage

// File: rtl/shared_mem_arbiter_rr.sv
// Two-way round-robin picker: a lone requester wins, and on a tie the core
// that did not win last time gets the grant.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates two cores onto one single-port shared memory; a write takes
// IDLE->ISSUE, a read takes IDLE->ISSUE->RDWAIT with data returned afterwards.
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int Ncores = NCORES_DEF,
    parameter int Lmem   = LMEM_DEF,
    parameter int TAM    = TAM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [Ncores-1:0] req,
    input  logic [Ncores-1:0] we,
    input  logic [Lmem-1:0]   addr0,
    input  logic [Lmem-1:0]   addr1,
    input  logic [TAM-1:0]    wdata0,
    input  logic [TAM-1:0]    wdata1,
    output logic [Ncores-1:0] gnt,
    output logic [Ncores-1:0] rvalid,
    output logic [TAM-1:0]    rdata0,
    output logic [TAM-1:0]    rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [Lmem-1:0]   mem_addr,
    output logic [TAM-1:0]    mem_wdata,
    input  logic [TAM-1:0]    mem_rdata
);

    state_t            state_q;
    logic              lastWin_q;
    logic              isCore_q;
    logic              isWe_q;
    logic [Lmem-1:0]   isAddr_q;
    logic [TAM-1:0]    isWdata_q;
    logic [Ncores-1:0] gnt_q;
    logic [Ncores-1:0] rvalid_q;
    logic              memEn_q;
    logic              memWe_q;
    logic [TAM-1:0]    rdata0_q;
    logic [TAM-1:0]    rdata1_q;

    logic [1:0]        pick;
    logic              winIdx;

    rr_arbiter2 u_rr (
        .req  (req),
        .last (lastWin_q),
        .pick (pick)
    );

    assign winIdx = pick[1];

    // Strobes default low each cycle so every pulse lasts exactly one cycle;
    // reset therefore also kills any access that is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lastWin_q <= 1'b1;
            isCore_q  <= 1'b0;
            isWe_q    <= 1'b0;
            isAddr_q  <= '0;
            isWdata_q <= '0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            memEn_q   <= 1'b0;
            memWe_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            memEn_q  <= 1'b0;
            memWe_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        isCore_q  <= winIdx;
                        isWe_q    <= we[winIdx];
                        isAddr_q  <= winIdx ? addr1 : addr0;
                        isWdata_q <= winIdx ? wdata1 : wdata0;
                        lastWin_q <= winIdx;
                        gnt_q     <= pick;
                        memEn_q   <= 1'b1;
                        memWe_q   <= we[winIdx];
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= isWe_q ? IDLE : RDWAIT;
                end
                RDWAIT: begin
                    if (isCore_q) begin
                        rdata1_q <= mem_rdata;
                    end else begin
                        rdata0_q <= mem_rdata;
                    end
                    rvalid_q[isCore_q] <= 1'b1;
                    state_q            <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_en    = memEn_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = isAddr_q;
    assign mem_wdata = isWdata_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural memory and a
// scoreboard of expected grants and read returns.
module tb_shared_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } grantExp_t;

    typedef struct {
        logic        core;
        logic [15:0] data;
    } readExp_t;

    grantExp_t   grantQ[$];
    readExp_t    readQ[$];
    logic [15:0] expMem [0:255];
    logic [15:0] tbMem [0:255];

    int checks   = 0;
    int failures = 0;

    shared_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                tbMem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= tbMem[mem_addr];
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushGrant(input logic core, input logic w, input logic [7:0] a, input logic [15:0] d);
        grantExp_t e;
        e.gnt   = core ? 2'b10 : 2'b01;
        e.we    = w;
        e.addr  = a;
        e.wdata = d;
        grantQ.push_back(e);
    endtask

    // Called in expected arbitration order so the memory model tracks serialization.
    task automatic applyStimulus(input logic core, input logic w, input logic [7:0] a, input logic [15:0] d);
        readExp_t r;
        pushGrant(core, w, a, d);
        if (w) begin
            expMem[a] = d;
        end else begin
            r.core = core;
            r.data = expMem[a];
            readQ.push_back(r);
        end
    endtask

    task automatic checkGrant(input int expLat, input bit keepReq);
        grantExp_t e;
        bit found;
        int lat;
        found = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                found = 1'b1;
                lat   = i;
                break;
            end
        end
        checkOutput("grant_seen", 32'(found), 32'd1);
        checkOutput("grant_queue_nonempty", 32'(grantQ.size() != 0), 32'd1);
        if (found && grantQ.size() != 0) begin
            e = grantQ.pop_front();
            checkOutput("gnt", 32'(gnt), 32'(e.gnt));
            checkOutput("grant_latency", 32'(lat), 32'(expLat));
            checkOutput("issue_mem_en", 32'(mem_en), 32'd1);
            checkOutput("issue_mem_we", 32'(mem_we), 32'(e.we));
            checkOutput("issue_mem_addr", 32'(mem_addr), 32'(e.addr));
            checkOutput("issue_mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            if (!keepReq) begin
                req = req & ~gnt;
            end
        end
    endtask

    task automatic checkRead();
        readExp_t e;
        bit found;
        int lat;
        found = 1'b0;
        lat   = 0;
        checkOutput("read_queue_nonempty", 32'(readQ.size() != 0), 32'd1);
        if (readQ.size() != 0) begin
            e = readQ.pop_front();
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                if (i == 1) begin
                    checkOutput("rdwait_mem_en", 32'(mem_en), 32'd0);
                end
                if (rvalid != 2'b00) begin
                    found = 1'b1;
                    lat   = i;
                    break;
                end
            end
            checkOutput("rvalid_seen", 32'(found), 32'd1);
            checkOutput("rvalid_latency", 32'(lat), 32'd2);
            checkOutput("rvalid", 32'(rvalid), e.core ? 32'd2 : 32'd1);
            checkOutput("rdata", e.core ? 32'(rdata1) : 32'(rdata0), 32'(e.data));
            @(negedge clk);
            checkOutput("rvalid_pulse_end", 32'(rvalid), 32'd0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        req    = 2'b00;
        we     = 2'b00;
        addr0  = 8'h00;
        addr1  = 8'h00;
        wdata0 = 16'h0000;
        wdata1 = 16'h0000;

        repeat (2) @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_rdata0", 32'(rdata0), 32'd0);
        checkOutput("rst_rdata1", 32'(rdata1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single write core0");
        req = 2'b01; we = 2'b01; addr0 = 8'h12; wdata0 = 16'hBEEF;
        applyStimulus(1'b0, 1'b1, 8'h12, 16'hBEEF);
        checkGrant(1, 1'b0);
        @(negedge clk);
        checkOutput("post_write_mem_en", 32'(mem_en), 32'd0);
        checkOutput("post_write_mem_addr_hold", 32'(mem_addr), 32'h12);

        $display("[TB] read-back core1");
        req = 2'b10; we = 2'b00; addr1 = 8'h12; wdata1 = 16'h0000;
        applyStimulus(1'b1, 1'b0, 8'h12, wdata1);
        checkGrant(1, 1'b0);
        checkRead();

        $display("[TB] tie after reset");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 2'b11; we = 2'b11;
        addr0 = 8'h05; wdata0 = 16'h1111;
        addr1 = 8'h05; wdata1 = 16'h2222;
        applyStimulus(1'b0, 1'b1, 8'h05, 16'h1111);
        applyStimulus(1'b1, 1'b1, 8'h05, 16'h2222);
        checkGrant(1, 1'b0);
        checkGrant(2, 1'b0);
        @(negedge clk);
        checkOutput("tie_final_mem", 32'(tbMem[8'h05]), 32'(expMem[8'h05]));

        $display("[TB] fairness with both requests held");
        req = 2'b11; we = 2'b11;
        addr0 = 8'h20; wdata0 = 16'hA0A0;
        addr1 = 8'h21; wdata1 = 16'hB1B1;
        for (int i = 0; i < 8; i++) begin
            if (i[0]) begin
                applyStimulus(1'b1, 1'b1, 8'h21, 16'hB1B1);
            end else begin
                applyStimulus(1'b0, 1'b1, 8'h20, 16'hA0A0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checkGrant((i == 0) ? 1 : 2, 1'b1);
        end
        req = 2'b00;
        @(negedge clk);

        $display("[TB] write then read same address");
        req = 2'b11; we = 2'b01;
        addr0 = 8'h30; wdata0 = 16'h1234;
        addr1 = 8'h30; wdata1 = 16'h0000;
        applyStimulus(1'b0, 1'b1, 8'h30, 16'h1234);
        applyStimulus(1'b1, 1'b0, 8'h30, 16'h0000);
        checkGrant(1, 1'b0);
        checkGrant(2, 1'b0);
        checkRead();

        $display("[TB] reset during read wait");
        req = 2'b01; we = 2'b00; addr0 = 8'h12;
        pushGrant(1'b0, 1'b0, 8'h12, wdata0);
        checkGrant(1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_rvalid", 32'(rvalid), 32'd0);
        checkOutput("abort_rdata0", 32'(rdata0), 32'd0);
        checkOutput("abort_rdata1", 32'(rdata1), 32'd0);
        checkOutput("abort_mem_en", 32'(mem_en), 32'd0);
        checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abort_idle_mem_en", 32'(mem_en), 32'd0);
            checkOutput("abort_idle_rvalid", 32'(rvalid), 32'd0);
        end

        $display("[TB] new access after abort");
        req = 2'b10; we = 2'b10; addr1 = 8'h07; wdata1 = 16'h7777;
        applyStimulus(1'b1, 1'b1, 8'h07, 16'h7777);
        checkGrant(1, 1'b0);
        @(negedge clk);
        checkOutput("final_write_mem", 32'(tbMem[8'h07]), 32'(expMem[8'h07]));
        checkOutput("grant_queue_drained", 32'(grantQ.size()), 32'd0);
        checkOutput("read_queue_drained", 32'(readQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
